beacon_rx_parser: RTL and testbench

//  Ingress stage directly upstream of learnCosts. Deserialises 16-bit beacon words from the radio,

---
 rtl/beacon_rx_parser_pkg.sv | 30 +++
 rtl/beacon_rx_parser_fifo.sv | 55 +++++
 rtl/beacon_rx_parser.sv | 172 +++++++++++++++++
 tb/tb_beacon_rx_parser.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beacon_rx_parser_pkg.sv
// Shared beacon definitions: sync word, word indices, parsed-frame layout, FSM encodings.
// BEACON_CHECKSUM_EN adds a seventh (checksum) word checked against the XOR of W1..W5.
package beacon_rx_parser_pkg;

    localparam int          FIELD_W   = 16;
    localparam logic [15:0] SYNC_WORD = 16'hA55A;

    localparam logic [2:0] IDX_SRC     = 3'd1;
    localparam logic [2:0] IDX_DST     = 3'd2;
    localparam logic [2:0] IDX_CLUSTER = 3'd3;
    localparam logic [2:0] IDX_BATTERY = 3'd4;
    localparam logic [2:0] IDX_VALUE   = 3'd5;

    // src occupies the top 16 bits of the 80-bit FIFO entry
    typedef struct packed {
        logic [FIELD_W-1:0] src;
        logic [FIELD_W-1:0] dst;
        logic [FIELD_W-1:0] cluster;
        logic [FIELD_W-1:0] battery;
        logic [FIELD_W-1:0] value;
    } frame_t;

    typedef enum logic [1:0] {P_HUNT, P_FIELDS, P_CHECK, P_COMMIT} parse_state_t;
    typedef enum logic [1:0] {O_IDLE, O_RUN, O_GAP} out_state_t;

    function automatic logic [FIELD_W-1:0] frame_xor(input frame_t f);
        return f.src ^ f.dst ^ f.cluster ^ f.battery ^ f.value;
    endfunction

endpackage

// File: rtl/beacon_rx_parser_fifo.sv
// Frame FIFO: DEPTH entries, synchronous push/pop, show-ahead head, async active-high reset.
// A push on a full FIFO succeeds when a pop happens in the same cycle.
module beacon_rx_parser_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/beacon_rx_parser.sv
// Beacon ingress: parses 16-bit radio words into frames, queues them and hands one at a time
// to the routing pipeline. Define BEACON_CHECKSUM_EN for 7-word frames with an XOR checksum.
module beacon_rx_parser
    import beacon_rx_parser_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx_valid,
    input  logic [15:0]            i_rx_data,
    input  logic                   i_pipe_done,
    output logic                   o_pipe_en,
    output logic [15:0]            o_f_src,
    output logic [15:0]            o_f_dst,
    output logic [15:0]            o_f_cluster,
    output logic [15:0]            o_f_battery,
    output logic [15:0]            o_f_value,
    output logic [7:0]             o_drop_cnt,
    output logic [$clog2(DEPTH):0] o_fifo_level
);
    localparam int                 IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    parse_state_t      r_p_state, w_p_next;
    out_state_t        r_o_state, w_o_next;
    logic [2:0]        r_idx, w_idx_next;
    logic [IDLE_W-1:0] r_idle, w_idle_next;
    frame_t            r_frame, w_frame_next;
    frame_t            r_f;
    frame_t            w_head;
    logic [7:0]        r_drop;
    logic              w_push, w_pop, w_drop;
    logic              w_full, w_empty, w_is_sync, w_timeout;

    assign w_is_sync = i_rx_valid && (i_rx_data == SYNC_WORD);
    assign w_timeout = (r_idle == IDLE_LAST);

    always_comb begin
        w_p_next     = r_p_state;
        w_idx_next   = r_idx;
        w_idle_next  = '0;
        w_frame_next = r_frame;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        case (r_p_state)
            P_HUNT: begin
                if (w_is_sync) begin
                    w_p_next   = P_FIELDS;
                    w_idx_next = IDX_SRC;
                end
            end
            P_FIELDS: begin
                if (i_rx_valid) begin
                    case (r_idx)
                        IDX_SRC:     w_frame_next.src     = i_rx_data;
                        IDX_DST:     w_frame_next.dst     = i_rx_data;
                        IDX_CLUSTER: w_frame_next.cluster = i_rx_data;
                        IDX_BATTERY: w_frame_next.battery = i_rx_data;
                        IDX_VALUE:   w_frame_next.value   = i_rx_data;
                        default:     w_frame_next         = r_frame;
                    endcase
                    if (r_idx == IDX_VALUE) begin
`ifdef BEACON_CHECKSUM_EN
                        w_p_next = P_CHECK;
`else
                        w_p_next = P_COMMIT;
`endif
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else if (w_timeout) begin
                    w_drop   = 1'b1;
                    w_p_next = P_HUNT;
                end else begin
                    w_idle_next = r_idle + 1'b1;
                end
            end
            P_CHECK: begin
                if (i_rx_valid) begin
                    if (i_rx_data == frame_xor(r_frame)) begin
                        w_p_next = P_COMMIT;
                    end else begin
                        w_drop   = 1'b1;
                        w_p_next = P_HUNT;
                    end
                end else if (w_timeout) begin
                    w_drop   = 1'b1;
                    w_p_next = P_HUNT;
                end else begin
                    w_idle_next = r_idle + 1'b1;
                end
            end
            P_COMMIT: begin
                if (w_full && !w_pop) begin
                    w_drop = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
                // a word in the commit cycle is judged as if already hunting
                if (w_is_sync) begin
                    w_p_next   = P_FIELDS;
                    w_idx_next = IDX_SRC;
                end else begin
                    w_p_next = P_HUNT;
                end
            end
            default: w_p_next = P_HUNT;
        endcase
    end

    always_comb begin
        w_o_next = r_o_state;
        w_pop    = 1'b0;
        case (r_o_state)
            O_IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_o_next = O_RUN;
                end
            end
            O_RUN:   if (i_pipe_done) w_o_next = O_GAP;
            O_GAP:   w_o_next = O_IDLE;
            default: w_o_next = O_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_p_state <= P_HUNT;
            r_o_state <= O_IDLE;
            r_idx     <= '0;
            r_idle    <= '0;
            r_frame   <= '0;
            r_f       <= '0;
            r_drop    <= '0;
        end else begin
            r_p_state <= w_p_next;
            r_o_state <= w_o_next;
            r_idx     <= w_idx_next;
            r_idle    <= w_idle_next;
            r_frame   <= w_frame_next;
            if (w_pop) r_f <= w_head;
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    beacon_rx_parser_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(frame_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_frame),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    assign o_pipe_en   = (r_o_state == O_RUN);
    assign o_f_src     = r_f.src;
    assign o_f_dst     = r_f.dst;
    assign o_f_cluster = r_f.cluster;
    assign o_f_battery = r_f.battery;
    assign o_f_value   = r_f.value;
    assign o_drop_cnt  = r_drop;

endmodule

// File: tb/tb_beacon_rx_parser.sv
// Randomised scoreboard bench for beacon_rx_parser: the driver pushes expected frames,
// a monitor pops and compares each frame the DUT presents on pipe_en.
module tb_beacon_rx_parser;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;
`ifdef BEACON_CHECKSUM_EN
    localparam int NW = 7;
`else
    localparam int NW = 6;
`endif

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] cluster;
        logic [15:0] battery;
        logic [15:0] value;
    } fr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [15:0] rx_data = '0;
    logic        man_done = 1'b0;
    logic        auto_done = 1'b0;
    logic        pipe_done;
    logic        pipe_en;
    logic [15:0] f_src, f_dst, f_cluster, f_battery, f_value;
    logic [7:0]  drop_cnt;
    logic [2:0]  fifo_level;

    assign pipe_done = man_done | auto_done;

    beacon_rx_parser #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .i_pipe_done  (pipe_done),
        .o_pipe_en    (pipe_en),
        .o_f_src      (f_src),
        .o_f_dst      (f_dst),
        .o_f_cluster  (f_cluster),
        .o_f_battery  (f_battery),
        .o_f_value    (f_value),
        .o_drop_cnt   (drop_cnt),
        .o_fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_err = 0;
    int  exp_drop = 0;
    bit  auto_en = 1'b0;
    fr_t sb[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [15:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic fr_t mk(input logic [15:0] s, d, c, b, v);
        fr_t f;
        f.src = s; f.dst = d; f.cluster = c; f.battery = b; f.value = v;
        return f;
    endfunction

    function automatic logic [15:0] xsum(input fr_t f);
        return f.src ^ f.dst ^ f.cluster ^ f.battery ^ f.value;
    endfunction

    function automatic logic [6:0][15:0] words_of(input fr_t f, input logic [15:0] chk_xor);
        logic [6:0][15:0] w;
        w[0] = 16'hA55A; w[1] = f.src; w[2] = f.dst; w[3] = f.cluster;
        w[4] = f.battery; w[5] = f.value; w[6] = xsum(f) ^ chk_xor;
        return w;
    endfunction

    function automatic int sat_drop();
        return (exp_drop > 255) ? 255 : exp_drop;
    endfunction

    // One idle gap of gap_len cycles after word gap_pos; a gap of TIMEOUT aborts the frame.
    task automatic send_frame(input fr_t f, input logic [15:0] chk_xor, input int gap_pos,
                              input int gap_len, input bit expect_ok);
        logic [6:0][15:0] w;
        bit bad;
        w = words_of(f, chk_xor);
        for (int i = 0; i < NW; i++) begin
            send_word(w[i]);
            if (i == gap_pos && i < NW - 1) begin
                idle(gap_len);
                if (gap_len >= TIMEOUT) begin
                    exp_drop++;
                    return;
                end
            end
        end
`ifdef BEACON_CHECKSUM_EN
        bad = (chk_xor != 16'h0000);
`else
        bad = 1'b0;
`endif
        if (bad) exp_drop++;
        else if (expect_ok) sb.push_back(f);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || pipe_en) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d frames still outstanding, required 0", sb.size());
        end
        idle(3);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pipe_en"}, pipe_en, 0);
        chk({tag, "_fields"}, {f_src, f_dst, f_cluster, f_battery, f_value}, 0);
        chk({tag, "_drop"}, drop_cnt, 0);
        chk({tag, "_level"}, fifo_level, 0);
    endtask

    // Monitor: compare each newly presented frame, and its stability until the next one.
    initial begin : monitor
        fr_t e;
        fr_t cap;
        bit  prev = 1'b0;
        cap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (pipe_en && !prev) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: src=%0h dst=%0h presented, none expected",
                                 f_src, f_dst);
                    end else begin
                        e = sb.pop_front();
                        chk("f_src", f_src, e.src);
                        chk("f_dst", f_dst, e.dst);
                        chk("f_cluster", f_cluster, e.cluster);
                        chk("f_battery", f_battery, e.battery);
                        chk("f_value", f_value, e.value);
                    end
                    cap = {f_src, f_dst, f_cluster, f_battery, f_value};
                end else if (prev) begin
                    chk("f_hold", {f_src, f_dst, f_cluster, f_battery, f_value}, cap);
                end
                prev = pipe_en;
            end
        end
    end

    // Pipeline model: finishes a presented frame after a random 0..3 cycle delay.
    initial begin : responder
        int d;
        forever begin
            @(posedge clk);
            #2;
            if (auto_en && pipe_en) begin
                d = $urandom_range(0, 3);
                repeat (d) @(posedge clk);
                #2;
                auto_done = 1'b1;
                @(posedge clk);
                #2;
                auto_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        fr_t f;
        logic [6:0][15:0] w;
        int gl, gp, nj;
        logic [15:0] cx, jw;

        idle(3);
        check_zero("reset");
        rst = 1'b0;
        idle(2);

        // Clean frame and 2-cycle presentation latency
        f = mk(16'h0001, 16'h0003, 16'h0001, 16'h0001, 16'h000A);
        send_frame(f, 16'h0000, -1, 0, 1'b1);
        chk("lat_commit", pipe_en, 0);
        tick();
        chk("lat_pop", pipe_en, 0);
        tick();
        chk("lat_run", pipe_en, 1);
        auto_en = 1'b1;
        drain(200);

`ifdef BEACON_CHECKSUM_EN
        // Checksum word 0000 is wrong for this frame
        send_frame(f, xsum(f), -1, 0, 1'b1);
        idle(4);
        chk("bad_chk_drop", drop_cnt, sat_drop());
        chk("bad_chk_no_en", pipe_en, 0);
        send_frame(mk(16'h0002, 16'h0004, 16'h0005, 16'h0006, 16'h0007), 16'h0000, -1, 0, 1'b1);
        drain(200);
`endif

        // Idle gap just below and exactly at TIMEOUT after W3
        send_frame(mk(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050), 16'h0000, 3, TIMEOUT - 1, 1'b1);
        drain(200);
        chk("gap_below_timeout_drop", drop_cnt, sat_drop());
        send_frame(mk(16'h0011, 16'h0021, 16'h0031, 16'h0041, 16'h0051), 16'h0000, 3, TIMEOUT, 1'b1);
        idle(2);
        chk("timeout_drop", drop_cnt, sat_drop());
        send_frame(mk(16'h0012, 16'h0022, 16'h0032, 16'h0042, 16'h0052), 16'h0000, -1, 0, 1'b1);
        drain(200);

        // Junk before SYNC and SYNC as data
        send_word(16'h1234);
        send_word(16'hFFFF);
        send_frame(mk(16'h0007, 16'hA55A, 16'h0008, 16'h0009, 16'h000B), 16'h0000, -1, 0, 1'b1);
        drain(200);
        chk("junk_drop", drop_cnt, sat_drop());

        // DEPTH+2 back-to-back frames with the pipeline stalled
        auto_en = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            f = mk(16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0300, 16'h0400, 16'h0500 + 16'(i));
            send_frame(f, 16'h0000, -1, 0, (i < DEPTH + 1));
            if (i == DEPTH + 1) exp_drop++;
        end
        idle(3);
        chk("full_level", fifo_level, DEPTH);
        chk("full_drop", drop_cnt, sat_drop());
        chk("full_pipe_en", pipe_en, 1);

        // pipe_done lands so that the pop and the next commit share a cycle on a full FIFO
        f = mk(16'h0777, 16'h0888, 16'h0999, 16'h0AAA, 16'h0BBB);
        w = words_of(f, 16'h0000);
        for (int i = 0; i < NW - 2; i++) send_word(w[i]);
        man_done = 1'b1;
        send_word(w[NW-2]);
        man_done = 1'b0;
        chk("gap_cycle", pipe_en, 0);
        send_word(w[NW-1]);
        sb.push_back(f);
        chk("idle_after_gap", pipe_en, 0);
        tick();
        chk("next_run", pipe_en, 1);
        chk("pushpop_level", fifo_level, DEPTH);
        chk("pushpop_drop", drop_cnt, sat_drop());
        auto_en = 1'b1;
        drain(500);
        chk("drained_level", fifo_level, 0);

        // Reset while presenting a frame and mid-way through another
        auto_en = 1'b0;
        send_frame(mk(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 16'h0C05), 16'h0000, -1, 0, 1'b1);
        idle(3);
        chk("run_before_rst", pipe_en, 1);
        send_word(16'hA55A);
        send_word(16'h1111);
        send_word(16'h2222);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        sb.delete();
        exp_drop = 0;
        idle(2);
        rst = 1'b0;
        auto_en = 1'b1;
        send_frame(mk(16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04, 16'h0D05), 16'h0000, -1, 0, 1'b1);
        drain(200);
        chk("post_rst_drop", drop_cnt, 0);

        // Randomised traffic
        for (int t = 0; t < 60; t++) begin
            gl = 0;
            while (sb.size() >= DEPTH && gl < 2000) begin
                tick();
                gl++;
            end
            if (gl >= 2000) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand_backlog: %0d frames outstanding, required < %0d", sb.size(), DEPTH);
            end
            nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                jw = 16'($urandom);
                if (jw == 16'hA55A) jw = 16'h0000;
                send_word(jw);
            end
            idle($urandom_range(0, 2));
            for (int k = 0; k < 5; k++) begin
                w[k] = ($urandom_range(0, 7) == 0) ? 16'hA55A : 16'($urandom);
            end
            f = mk(w[0], w[1], w[2], w[3], w[4]);
            gp = $urandom_range(0, NW - 2);
            case ($urandom_range(0, 15))
                0:       gl = TIMEOUT;
                1:       gl = TIMEOUT - 1;
                default: gl = $urandom_range(0, 2);
            endcase
`ifdef BEACON_CHECKSUM_EN
            cx = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
`else
            cx = 16'h0000;
`endif
            send_frame(f, cx, gp, gl, 1'b1);
            idle(2);
            chk("rand_drop", drop_cnt, sat_drop());
        end
        drain(2000);
        chk("final_drop", drop_cnt, sat_drop());
        chk("final_level", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
